branch_pc_ctrl: RTL

Fetch-side PC sequencer and pipeline-flush controller for the 4-bit processor core. It owns the program counter and advances it each cycle. It consumes the resolved branch result from the Branch unit (jumpAddress plus its NOP/not-taken flag) and redirects the PC on taken branches. It squashes the wrong-path instructions already fetched by asserting a flush to the IF/ID stages for a fixed number of cycles, and it handles upstream stalls and a halt instruction.

---
 rtl/branch_pc_ctrl_if.sv | 25 ++
 rtl/branch_pc_ctrl.sv | 92 +++++++++
 2 files changed

// File: rtl/branch_pc_ctrl_if.sv
// Fetch-control bus between the EX/branch side (master) and the PC sequencer (slave).
interface branch_pc_ctrl_if #(
  parameter int unsigned bus   = 4,
  parameter int unsigned CNT_W = 8
);
  logic             stall;
  logic             halt_req;
  logic             br_valid;
  logic             br_nop;
  logic [bus-1:0]   jump_address;
  logic [bus-1:0]   pc;
  logic             flush;
  logic             halted;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output stall, halt_req, br_valid, br_nop, jump_address,
    input  pc, flush, halted, taken_cnt
  );

  modport slave (
    input  stall, halt_req, br_valid, br_nop, jump_address,
    output pc, flush, halted, taken_cnt
  );
endinterface

// File: rtl/branch_pc_ctrl.sv
// PC sequencer with taken-branch redirect, timed IF/ID flush, stall hold and halt.
module branch_pc_ctrl #(
  parameter int unsigned bus          = 4,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 8
) (
  input logic               clk,
  input logic               rst,
  branch_pc_ctrl_if.slave   bif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [bus-1:0]   PC_ONE     = 1;
  localparam logic [CNT_W-1:0] CNT_ONE    = 1;
  localparam logic [3:0]       FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_t           state_q;
  logic [bus-1:0]   pc_q;
  logic             flush_q;
  logic             halted_q;
  logic [CNT_W-1:0] taken_q;
  logic [3:0]       fcnt_q;

  logic             taken_br;
  logic [bus-1:0]   pc_inc;

  assign taken_br = bif.br_valid && !bif.br_nop;
  assign pc_inc   = pc_q + PC_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      pc_q     <= '0;
      flush_q  <= 1'b0;
      halted_q <= 1'b0;
      taken_q  <= '0;
      fcnt_q   <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (bif.halt_req) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
            flush_q  <= 1'b0;
          end else if (taken_br) begin
            pc_q    <= bif.jump_address;
            flush_q <= 1'b1;
            fcnt_q  <= FLUSH_INIT;
            if (taken_q != '1) taken_q <= taken_q + CNT_ONE;
            state_q <= FLUSH;
          end else if (bif.stall) begin
            flush_q <= 1'b0;
          end else begin
            pc_q    <= pc_inc;
            flush_q <= 1'b0;
          end
        end
        FLUSH: begin
          // Branch/halt here come from squashed instructions, so only stall matters.
          if (!bif.stall) begin
            pc_q <= pc_inc;
            if (fcnt_q == '0) begin
              flush_q <= 1'b0;
              state_q <= RUN;
            end else begin
              fcnt_q <= fcnt_q - 4'd1;
            end
          end
        end
        HALT: begin
          flush_q  <= 1'b0;
          halted_q <= 1'b1;
        end
        default: begin
          state_q <= RUN;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  assign bif.pc        = pc_q;
  assign bif.flush     = flush_q;
  assign bif.halted    = halted_q;
  assign bif.taken_cnt = taken_q;

endmodule
